n_bit_sqrt_seq: RTL and testbench
=================================

Name: n_bit_sqrt_seq

Overview:
- Sequential integer square-root unit; inverse of the combinational N-bit squarer.
- Takes a 2N-bit radicand and produces the N-bit floor root and an (N+1)-bit remainder, one root bit per clock (restoring digit-by-digit).
- Sits in the arithmetic datapath behind valid/ready handshakes so it can follow a squarer or feed downstream compare logic.

Parameters:
- N, 4, root width; radicand width is 2N, remainder width is N+1; legal range 2..32.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, radicand present.
- in_ready, output, 1, unit idle and able to accept.
- radicand, input, 2N, unsigned operand; sampled only on accept.
- out_valid, output, 1, result held on root/rem.
- out_ready, input, 1, consumer takes result.
- root, output, N, floor(sqrt(radicand)).
- rem, output, N+1, radicand - root*root; always <= 2*root.
- busy, output, 1, high in CALC or DONE.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (rst=1 at an edge), from any state including mid-CALC or DONE: state=IDLE, in_ready=1, out_valid=0, busy=0, root=0, rem=0, iteration counter=0. Any in-flight operation is dropped with no output.
- IDLE: in_ready=1. On an edge with in_valid=1, latch radicand into a 2N-bit shift register, clear partial root (N bits) and partial remainder (N+2 bits), load counter=N-1, then go to CALC. in_valid=0 leaves the unit in IDLE.
- CALC: in_ready=0. Each cycle:
  - trial = {prem, rad[2N-1:2N-2]} - {proot, 2'b01}, computed at N+2 bits.
  - If trial is non-negative: prem=trial, proot={proot,1}. Otherwise: prem={prem, top two radicand bits}, proot={proot,0}.
  - Shift the radicand register left by 2.
  - Counter decrements. On the edge where counter==0, copy proot to root and prem[N:0] to rem, set out_valid=1, go to DONE.
- Latency: radicand accepted at edge T gives out_valid=1 after edge T+N. No pipelining. Minimum initiation interval is N+2 cycles (accept, N calc edges, drain, IDLE).
- DONE:
  - out_valid=1; root/rem are stable until handshake.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. root and rem keep their last values.
  - out_ready=0 holds the state indefinitely.
  - in_valid is ignored in CALC and DONE because in_ready=0.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The new operand is accepted from IDLE in a later cycle.
- Radicand 0 returns root=0, rem=0 with normal latency. No early termination: latency is data-independent.
- Max radicand 2^(2N)-1 returns root=2^N-1, rem=2^(N+1)-2, which fits in N+1 bits.
- Input changes on radicand outside the accept edge have no effect.

Optional Feature:
- Macro N_BIT_SQRT_CHECK_EN.
- Defined:
  - Keeps a copy of the accepted radicand.
  - Adds output check_err (1 bit, reset 0), registered on the CALC->DONE edge as (root*root + rem != radicand_copy) OR (rem > 2*root).
  - check_err is valid while out_valid=1 and clears on the output handshake.
- Undefined: no copy register, no multiplier, and no check_err port. Functional behaviour and latency are otherwise identical.

Decomposition:
- Package n_bit_sqrt_pkg holds:
  - state enum (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - width helper constants (root width, remainder width N+1, partial width N+2);
  - the counter width function clog2(N).
- One natural sub-module: n_bit_sqrt_step.
  - Combinational single iteration.
  - Inputs: prem, proot, two radicand bits.
  - Outputs: next prem, next root bit.
  - Instantiated once in the CALC datapath.
- The FSM, counter and registers live in the top module.

Test Plan:
- N=4, radicand=8'd144, out_ready=1 -> out_valid after exactly 4 cycles from accept; root=12, rem=0; in_ready=0 in between.
- N=4, radicand=8'd255 -> root=15, rem=30. Then radicand=8'd0 -> root=0, rem=0. Then radicand=8'd17 -> root=4, rem=1.
- Backpressure: radicand=8'd50, out_ready=0 for 6 cycles after out_valid -> root=7, rem=1 held stable; in_valid=1 with radicand=8'd9 during that window is not accepted. Raise out_ready -> IDLE, then 9 is accepted -> root=3, rem=0.
- Reset mid-operation: accept 8'd200, assert rst on the 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, root=0, rem=0. Then 8'd200 -> root=14, rem=4.
- Exhaustive N=4: all 256 radicands back-to-back -> each result satisfies root^2+rem==radicand and rem<=2*root. With N_BIT_SQRT_CHECK_EN defined, check_err stays 0 throughout.
- N=8, radicand=16'hFFFF -> root=255, rem=510 after 8 cycles.

Source files
------------

// File: rtl/n_bit_sqrt_pkg.sv
// Shared types and width helpers for the sequential integer square-root unit.
package n_bit_sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int root_w(input int n);
      return n;
   endfunction

   function automatic int rem_w(input int n);
      return n + 1;
   endfunction

   function automatic int part_w(input int n);
      return n + 2;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/n_bit_sqrt_step.sv
// One restoring square-root iteration: trial subtract of {proot,01} from {prem,bits}.
module n_bit_sqrt_step
   import n_bit_sqrt_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N+1:0] prem,
   input  logic [N-1:0] proot,
   input  logic [1:0]   bits,
   output logic [N+1:0] prem_n,
   output logic         rbit
);

   logic         borrow;
   logic [N+1:0] trial;
   logic         neg;

   // Upper prem bits are zero for legal operands; a set bit would make the trial positive.
   always_comb begin
      {borrow, trial} = {1'b0, prem[N-1:0], bits} - {1'b0, proot, 2'b01};
      neg    = borrow & ~(|prem[N+1:N]);
      rbit   = ~neg;
      prem_n = neg ? {prem[N-1:0], bits} : trial;
   end

endmodule

// File: rtl/n_bit_sqrt_seq.sv
// Sequential floor square root, one root bit per clock, valid/ready on both sides.
// Optional self-check output check_err when N_BIT_SQRT_CHECK_EN is defined.
module n_bit_sqrt_seq
   import n_bit_sqrt_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] radicand,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   root,
   output logic [N:0]     rem,
   output logic           busy
`ifdef N_BIT_SQRT_CHECK_EN
   ,
   output logic           check_err
`endif
);

   localparam int RW = root_w(N);
   localparam int MW = rem_w(N);
   localparam int PW = part_w(N);
   localparam int CW = clog2(N);

   state_t          state;
   logic [2*N-1:0]  rad_sr;
   logic [RW-1:0]   proot;
   logic [PW-1:0]   prem;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   prem_n;
   logic            rbit;
   logic [RW-1:0]   root_n;

   n_bit_sqrt_step #(.N(N)) u_step (
      .prem   (prem),
      .proot  (proot),
      .bits   (rad_sr[2*N-1:2*N-2]),
      .prem_n (prem_n),
      .rbit   (rbit)
   );

   assign root_n   = {proot[RW-2:0], rbit};
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

`ifdef N_BIT_SQRT_CHECK_EN
   logic [2*N-1:0] rad_copy;
   logic [2*N+1:0] rn_w;
   logic [2*N+1:0] recon;
   logic           calc_err;

   always_comb begin
      rn_w     = {{(N+2){1'b0}}, root_n};
      recon    = rn_w * rn_w + {{(N+1){1'b0}}, prem_n[MW-1:0]};
      calc_err = (recon != {2'b00, rad_copy}) || (prem_n[MW-1:0] > {root_n, 1'b0});
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rad_sr    <= '0;
         proot     <= '0;
         prem      <= '0;
         cnt       <= '0;
         root      <= '0;
         rem       <= '0;
         out_valid <= 1'b0;
`ifdef N_BIT_SQRT_CHECK_EN
         rad_copy  <= '0;
         check_err <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  rad_sr <= radicand;
                  proot  <= '0;
                  prem   <= '0;
                  cnt    <= CW'(N - 1);
                  state  <= CALC;
`ifdef N_BIT_SQRT_CHECK_EN
                  rad_copy <= radicand;
`endif
               end
            end
            CALC: begin
               prem   <= prem_n;
               proot  <= root_n;
               rad_sr <= {rad_sr[2*N-3:0], 2'b00};
               if (cnt == '0) begin
                  root      <= root_n;
                  rem       <= prem_n[MW-1:0];
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef N_BIT_SQRT_CHECK_EN
                  check_err <= calc_err;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
`ifdef N_BIT_SQRT_CHECK_EN
                  check_err <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_n_bit_sqrt_seq.sv
// Scoreboard bench for n_bit_sqrt_seq at N=4 (directed + exhaustive) and N=8 (max operand).
module tb_n_bit_sqrt_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0] radicand;
   logic [3:0] root;
   logic [4:0] rem;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [15:0] radicand8;
   logic [7:0]  root8;
   logic [8:0]  rem8;

`ifdef N_BIT_SQRT_CHECK_EN
   logic check_err, check_err8;
`endif

   typedef struct {
      logic [7:0] x;
      logic [3:0] r;
      logic [4:0] m;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   n_bit_sqrt_seq #(.N(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .radicand(radicand), .out_valid(out_valid), .out_ready(out_ready),
      .root(root), .rem(rem), .busy(busy)
`ifdef N_BIT_SQRT_CHECK_EN
      , .check_err(check_err)
`endif
   );

   n_bit_sqrt_seq #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .radicand(radicand8), .out_valid(out_valid8), .out_ready(out_ready8),
      .root(root8), .rem(rem8), .busy(busy8)
`ifdef N_BIT_SQRT_CHECK_EN
      , .check_err(check_err8)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   function automatic exp_t model(input logic [7:0] x);
      exp_t e;
      int   r;
      r = 0;
      while ((r + 1) * (r + 1) <= int'(x)) r++;
      e.x = x;
      e.r = 4'(r);
      e.m = 5'(int'(x) - r * r);
      return e;
   endfunction

   task automatic do_op(input logic [7:0] x, input int stall);
      exp_t e;
      int   w, lat;
      w = 0;
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      check("ready_wait", 32'(in_ready), 32'd1);
      radicand = x;
      in_valid = 1'b1;
      sb.push_back(model(x));
      @(posedge clk); #1;
      in_valid = 1'b0;
      radicand = 8'($urandom);
      check("calc_hs", {30'd0, in_ready, busy}, 32'd1);
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      check("latency", lat, 4);
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("root", 32'(root), 32'(e.r));
      check("rem", 32'(rem), 32'(e.m));
      check("identity", 32'(root) * 32'(root) + 32'(rem), 32'(e.x));
      check("rem_bound", 32'(32'(rem) <= 2 * 32'(root)), 32'd1);
`ifdef N_BIT_SQRT_CHECK_EN
      check("check_err", 32'(check_err), 32'd0);
`endif
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         radicand = 8'd9;
         @(posedge clk); #1;
         check("hold_state", {29'd0, out_valid, in_ready, busy}, 32'd5);
         check("hold_data", {23'd0, root, rem}, {23'd0, e.r, e.m});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("drain_state", {29'd0, out_valid, in_ready, busy}, 32'd2);
      check("drain_data", {23'd0, root, rem}, {23'd0, e.r, e.m});
   endtask

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; radicand = 8'd0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; radicand8 = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
      check("rst_data", {23'd0, root, rem}, 32'd0);
      rst = 1'b0;

      do_op(8'd144, 0);
      do_op(8'd255, 0);
      do_op(8'd0, 0);
      do_op(8'd17, 0);
      do_op(8'd50, 6);
      do_op(8'd9, 0);

      // Abort an operation in flight; its scoreboard entry must never be consumed.
      radicand = 8'd200; in_valid = 1'b1;
      sb.push_back(model(8'd200));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb.pop_back());
      check("midrst_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
      check("midrst_data", {23'd0, root, rem}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("midrst_quiet", {30'd0, out_valid, busy}, 32'd0);
      end
      do_op(8'd200, 0);

      for (int i = 0; i < 256; i++) do_op(8'(i), 0);
      check("sb_drained", sb.size(), 0);

      radicand8 = 16'hFFFF; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
      check("n8_latency", lat, 8);
      check("n8_root", 32'(root8), 32'd255);
      check("n8_rem", 32'(rem8), 32'd510);
`ifdef N_BIT_SQRT_CHECK_EN
      check("n8_check_err", 32'(check_err8), 32'd0);
`endif
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      check("n8_drain", {30'd0, out_valid8, in_ready8}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
